// File: rtl/filtro_pb200_ctrl.sv
// Sequencing controller for the 200 Hz second-order low-pass IIR datapath (direct form II).
// For every sample strobe it runs one fixed schedule of five multiply-add operations on the
// shared registered arithmetic unit (resultado = dato1*dato2 + dato3):
//   f(k) = u(k) + c0*f(k-1) + c1*f(k-2)
//   y(k) = b0*f(k) + b1*f(k-1) + b0*f(k-2)
// It drives only enables and mux selects; it never touches data.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-low reset
//   start    one-cycle sample strobe (new uk valid)
//   en1..en7 load strobes: Y, F, F1, F2, acum1, acum2, acum3
//   selmuxS  signal select      (0 fk, 1 fk1, 2 fk2)
//   selmuxC  coefficient select (0 c0, 1 c1, 2 b0, 3 b1)
//   selmuxZ  addend select      (0 zero, 1 uk, 2 acum1, 3 acum2, 4 acum3)
//   busy     schedule in progress
//   done     one-cycle pulse, yk updated
//   overrun  sticky: start seen while busy
module filtro_pb200_ctrl #(
  parameter int unsigned ARIT_LAT = 1  // 1..4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  // Order matters: each ISS is followed by its WAIT, and OP4_WAIT by DONE, so "+1" advances.
  typedef enum logic [3:0] {
    StIdle,
    StShift,
    StOp0Iss, StOp0Wait,
    StOp1Iss, StOp1Wait,
    StOp2Iss, StOp2Wait,
    StOp3Iss, StOp3Wait,
    StOp4Iss, StOp4Wait,
    StDone
  } state_e;

  localparam logic [1:0] LastCnt = 2'(ARIT_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       overrun_q, overrun_d;

  logic [6:0] en_vec;   // bit 0 = en1 ... bit 6 = en7
  logic [6:0] op_en;    // enable owned by the current op
  logic       op_wait;  // current state is an OPn_WAIT

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: state_d = StOp0Iss;
      StOp0Iss, StOp1Iss, StOp2Iss, StOp3Iss, StOp4Iss: begin
        state_d = state_e'(state_q + 4'd1);
        cnt_d   = 2'd0;
      end
      StOp0Wait, StOp1Wait, StOp2Wait, StOp3Wait, StOp4Wait: begin
        if (cnt_q == LastCnt) state_d = state_e'(state_q + 4'd1);
        else                  cnt_d   = cnt_q + 2'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    en_vec  = 7'b0;
    op_en   = 7'b0;
    op_wait = 1'b0;
    selmuxS = 3'd0;
    selmuxC = 2'd0;
    selmuxZ = 3'd0;
    done    = 1'b0;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StShift: en_vec = 7'b0001100;  // en3 and en4 shift the delay line together
      StOp0Iss, StOp0Wait: begin
        selmuxS = 3'd1; selmuxC = 2'd0; selmuxZ = 3'd1; op_en = 7'b0010000;
        op_wait = (state_q == StOp0Wait);
      end
      StOp1Iss, StOp1Wait: begin
        selmuxS = 3'd2; selmuxC = 2'd1; selmuxZ = 3'd2; op_en = 7'b0000010;
        op_wait = (state_q == StOp1Wait);
      end
      StOp2Iss, StOp2Wait: begin
        selmuxS = 3'd0; selmuxC = 2'd2; selmuxZ = 3'd0; op_en = 7'b0100000;
        op_wait = (state_q == StOp2Wait);
      end
      StOp3Iss, StOp3Wait: begin
        selmuxS = 3'd1; selmuxC = 2'd3; selmuxZ = 3'd3; op_en = 7'b1000000;
        op_wait = (state_q == StOp3Wait);
      end
      StOp4Iss, StOp4Wait: begin
        selmuxS = 3'd2; selmuxC = 2'd2; selmuxZ = 3'd4; op_en = 7'b0000001;
        op_wait = (state_q == StOp4Wait);
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
    // Result is valid only in the final WAIT cycle
    if (op_wait && (cnt_q == LastCnt)) en_vec = op_en;
  end

  assign overrun_d = overrun_q | (start & busy);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign {en7, en6, en5, en4, en3, en2, en1} = en_vec;
  assign overrun = overrun_q;

endmodule
